// File: rtl/xgemac_rx_unloader_if.sv
// Signal bundle between the 10G MAC receive FIFO read port, the unloader and the downstream stream.
// master = unloader side, slave = MAC/stream side.
interface xgemac_rx_unloader_if #(
    parameter int CNT_W = 32
) ();
    logic             pkt_rx_avail;
    logic             pkt_rx_ren;
    logic             pkt_rx_val;
    logic             pkt_rx_sop;
    logic             pkt_rx_eop;
    logic             pkt_rx_err;
    logic [63:0]      pkt_rx_data;
    logic [2:0]       pkt_rx_mod;

    logic             out_val;
    logic             out_rdy;
    logic [63:0]      out_data;
    logic             out_sop;
    logic             out_eop;
    logic             out_err;
    logic [2:0]       out_mod;

    logic             ovf;
    logic [CNT_W-1:0] rx_pkt_cnt;
    logic [CNT_W-1:0] rx_err_cnt;

    modport master (
        input  pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err,
               pkt_rx_data, pkt_rx_mod, out_rdy,
        output pkt_rx_ren, out_val, out_data, out_sop, out_eop, out_err, out_mod,
               ovf, rx_pkt_cnt, rx_err_cnt
    );

    modport slave (
        output pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err,
               pkt_rx_data, pkt_rx_mod, out_rdy,
        input  pkt_rx_ren, out_val, out_data, out_sop, out_eop, out_err, out_mod,
               ovf, rx_pkt_cnt, rx_err_cnt
    );
endinterface

// File: rtl/xgemac_rx_unloader.sv
// Drains packets from the XGEMAC receive FIFO into a 4-entry elastic buffer feeding a valid/ready stream.
// Statistics counters exist only when XGEMAC_RX_STATS_EN is defined.
//
// state | meaning
// IDLE  | no packet being read; wait for pkt_rx_avail
// READ  | issuing pkt_rx_ren until the eop word returns
module xgemac_rx_unloader #(
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_156m25,
    input  logic                 reset_156m25_n,
    xgemac_rx_unloader_if.master bus
);
    typedef enum logic {IDLE, READ} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } word_t;

    state_t      state, state_nxt;
    word_t       mem [4];
    word_t       in_word;
    word_t       head;
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        push, pop, full, wr_en, last_word;
    logic        ovf_q;
    logic        ren;

    assign in_word   = '{data: bus.pkt_rx_data, sop: bus.pkt_rx_sop, eop: bus.pkt_rx_eop,
                         mod: bus.pkt_rx_mod, err: bus.pkt_rx_err};
    assign push      = bus.pkt_rx_val;
    assign last_word = bus.pkt_rx_val && bus.pkt_rx_eop;
    assign full      = (count == 3'(FIFO_DEPTH));
    assign wr_en     = push && !full;
    assign pop       = bus.out_val && bus.out_rdy;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state  <= IDLE;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_en) wr_ptr <= wr_ptr + 2'd1;
            if (pop)   rd_ptr <= rd_ptr + 2'd1;
            if (wr_en && !pop)      count <= count + 3'd1;
            else if (!wr_en && pop) count <= count - 3'd1;
            if (push && full) ovf_q <= 1'b1;
        end
    end

    // Storage is never reset: emptiness is carried by count, and the outputs are masked when empty.
    always_ff @(posedge clk_156m25) begin
        if (wr_en) mem[wr_ptr] <= in_word;
    end

    // Read enable needs two free entries: one for the word already in flight, one for this request.
    always_comb begin
        state_nxt = state;
        ren       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pkt_rx_avail) state_nxt = READ;
            end
            READ: begin
                ren = (count <= 3'd2) && !last_word;
                if (last_word) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.pkt_rx_ren = ren;
    assign bus.out_val    = (count != 3'd0);
    assign bus.out_data   = bus.out_val ? head.data : 64'd0;
    assign bus.out_sop    = bus.out_val & head.sop;
    assign bus.out_eop    = bus.out_val & head.eop;
    assign bus.out_err    = bus.out_val & head.err;
    assign bus.out_mod    = bus.out_val ? head.mod : 3'd0;
    assign bus.ovf        = ovf_q;

`ifdef XGEMAC_RX_STATS_EN
    logic [CNT_W-1:0] pkt_cnt, err_cnt;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else if (pop && head.eop) begin
            pkt_cnt <= pkt_cnt + ONE;
            if (head.err) err_cnt <= err_cnt + ONE;
        end
    end

    assign bus.rx_pkt_cnt = pkt_cnt;
    assign bus.rx_err_cnt = err_cnt;
`else
    assign bus.rx_pkt_cnt = {CNT_W{1'b0}};
    assign bus.rx_err_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_xgemac_rx_unloader.sv
// Scoreboard bench for xgemac_rx_unloader: a MAC model answers pkt_rx_ren one cycle later,
// a monitor checks every popped word, flow-control rules and statistics against a packet-level model.
module tb_xgemac_rx_unloader;
    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } word_t;

    logic clk;
    logic rst_n;

    xgemac_rx_unloader_if #(.CNT_W(32)) bus ();

    xgemac_rx_unloader #(.CNT_W(32), .FIFO_DEPTH(4)) dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    word_t mac_q[$];
    word_t exp_q[$];
    int    exp_pkts = 0;
    int    exp_errs = 0;
    int    ren_cycles = 0;
    int    words_sent = 0;
    int    rdy_mode = 0;
    logic  hold = 1'b0;
    word_t held;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add_pkt(int len, logic err, logic [2:0] mod);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.data = {$urandom, $urandom};
            w.sop  = (i == 0);
            w.eop  = (i == len - 1);
            w.mod  = (i == len - 1) ? mod : 3'd0;
            w.err  = (i == len - 1) ? err : 1'b0;
            mac_q.push_back(w);
        end
    endtask

    task automatic drive_idle();
        bus.pkt_rx_val  = 1'b0;
        bus.pkt_rx_sop  = 1'b0;
        bus.pkt_rx_eop  = 1'b0;
        bus.pkt_rx_err  = 1'b0;
        bus.pkt_rx_mod  = 3'd0;
        bus.pkt_rx_data = 64'd0;
    endtask

    // One clock of MAC behaviour: a read enable seen this cycle returns a word next cycle.
    task automatic step();
        logic  r;
        word_t w;
        @(negedge clk);
        r = bus.pkt_rx_ren;
        if (r) ren_cycles++;
        @(posedge clk);
        #1;
        drive_idle();
        if (r) begin
            if (mac_q.size() == 0) begin
                chk("ren_without_data", 64'(r), 64'd0);
            end else begin
                w = mac_q.pop_front();
                bus.pkt_rx_val  = 1'b1;
                bus.pkt_rx_data = w.data;
                bus.pkt_rx_sop  = w.sop;
                bus.pkt_rx_eop  = w.eop;
                bus.pkt_rx_mod  = w.mod;
                bus.pkt_rx_err  = w.err;
                words_sent++;
            end
        end
        bus.pkt_rx_avail = (mac_q.size() > 0);
        case (rdy_mode)
            0:       bus.out_rdy = 1'b1;
            1:       bus.out_rdy = 1'b0;
            2:       bus.out_rdy = ~bus.out_rdy;
            default: bus.out_rdy = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic drain(int bound);
        int n = 0;
        do begin
            step();
            n++;
        end while ((mac_q.size() + exp_q.size()) != 0 && n < bound);
        chk("drain_complete", 64'(mac_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_ren"},     64'(bus.pkt_rx_ren), 64'd0);
        chk({tag, "_out_val"}, 64'(bus.out_val), 64'd0);
        chk({tag, "_data"},    bus.out_data, 64'd0);
        chk({tag, "_flags"},   64'({bus.out_sop, bus.out_eop, bus.out_err, bus.out_mod}), 64'd0);
        chk({tag, "_ovf"},     64'(bus.ovf), 64'd0);
        chk({tag, "_cnts"},    {bus.rx_pkt_cnt, bus.rx_err_cnt}, 64'd0);
    endtask

    // Monitor: flow-control rules, stability under stall, and in-order delivery.
    always @(negedge clk) begin
        word_t got, e;
        if (rst_n) begin
            got = '{data: bus.out_data, sop: bus.out_sop, eop: bus.out_eop,
                    mod: bus.out_mod, err: bus.out_err};
            if (bus.pkt_rx_ren && (exp_q.size() > 2 || (bus.pkt_rx_val && bus.pkt_rx_eop)))
                chk("ren_gate", 64'(bus.pkt_rx_ren), 64'd0);
            chk("out_val", 64'(bus.out_val), 64'(exp_q.size() > 0));
            if (hold) chk("stall_stable", 64'({bus.out_val, got} != {1'b1, held}), 64'd0);
            chk("ovf", 64'(bus.ovf), 64'd0);
            chk("rx_pkt_cnt", 64'(bus.rx_pkt_cnt), 64'(exp_pkts));
            chk("rx_err_cnt", 64'(bus.rx_err_cnt), 64'(exp_errs));
            if (bus.out_val && bus.out_rdy && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("word_data", got.data, e.data);
                chk("word_ctl", 64'({got.sop, got.eop, got.mod, got.err}),
                                64'({e.sop, e.eop, e.mod, e.err}));
`ifdef XGEMAC_RX_STATS_EN
                if (e.eop) begin
                    exp_pkts++;
                    if (e.err) exp_errs++;
                end
`endif
            end
            hold = bus.out_val && !bus.out_rdy;
            held = got;
            if (bus.pkt_rx_val)
                exp_q.push_back('{data: bus.pkt_rx_data, sop: bus.pkt_rx_sop, eop: bus.pkt_rx_eop,
                                  mod: bus.pkt_rx_mod, err: bus.pkt_rx_err});
        end
    end

    initial begin
        int pkts0;
        int errs0;
        rst_n = 1'b0;
        bus.pkt_rx_avail = 1'b0;
        bus.out_rdy = 1'b1;
        drive_idle();
        #12;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 3-word packet, downstream always ready
        rdy_mode = 0;
        add_pkt(3, 1'b0, 3'd5);
        ren_cycles = 0;
        drain(100);
        chk("pkt3_ren_cycles", 64'(ren_cycles), 64'd3);
`ifdef XGEMAC_RX_STATS_EN
        chk("pkt3_pkt_cnt", 64'(bus.rx_pkt_cnt), 64'd1);
`else
        chk("pkt3_pkt_cnt", 64'(bus.rx_pkt_cnt), 64'd0);
`endif

        // 10-word packet against a stalled sink: exactly four words fetched, then reads stop
        rdy_mode = 1;
        add_pkt(10, 1'b0, 3'd2);
        ren_cycles = 0;
        repeat (20) step();
        chk("stall_ren_cycles", 64'(ren_cycles), 64'd4);
        chk("stall_ren_low", 64'(bus.pkt_rx_ren), 64'd0);
        chk("stall_out_val", 64'(bus.out_val), 64'd1);
        rdy_mode = 0;
        drain(200);

        // back-to-back single-word packets
        pkts0 = exp_pkts;
        add_pkt(1, 1'b0, 3'd0);
        add_pkt(1, 1'b0, 3'd7);
        drain(100);
`ifdef XGEMAC_RX_STATS_EN
        chk("b2b_pkts", 64'(exp_pkts - pkts0), 64'd2);
`endif

        // error on eop
        errs0 = exp_errs;
        add_pkt(2, 1'b1, 3'd3);
        drain(100);
`ifdef XGEMAC_RX_STATS_EN
        chk("err_pkt_cnt", 64'(bus.rx_err_cnt), 64'(errs0 + 1));
`else
        chk("err_pkt_cnt", 64'(bus.rx_err_cnt), 64'd0);
`endif

        // reset while word 2 of a 6-word packet is on the bus
        add_pkt(6, 1'b0, 3'd1);
        words_sent = 0;
        begin
            int n = 0;
            while (words_sent < 3 && n < 100) begin
                step();
                n++;
            end
            chk("reset_reach_word2", 64'(words_sent), 64'd3);
        end
        #1 rst_n = 1'b0;
        #1 check_zero("midpkt_reset");
        mac_q.delete();
        exp_q.delete();
        exp_pkts = 0;
        exp_errs = 0;
        hold = 1'b0;
        drive_idle();
        bus.pkt_rx_avail = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        add_pkt(4, 1'b0, 3'd6);
        drain(100);

        // 64-word packet with toggling ready
        rdy_mode = 2;
        add_pkt(64, 1'b0, 3'd4);
        drain(1000);

        // random packets and random backpressure
        rdy_mode = 3;
        for (int i = 0; i < 30; i++)
            add_pkt($urandom_range(1, 8), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        drain(5000);
        rdy_mode = 0;
        repeat (3) step();

        chk("final_ovf", 64'(bus.ovf), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
